// File: rtl/main_mem_responder.sv
// Block-read memory responder: waits LATENCY cycles after a request, then
// streams the four words of the addressed 4-word block, then pulses done.
module main_mem_responder #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WORD_W-1:0] wrData,
    output logic              busy,
    output logic              ready,
    output logic [1:0]        offset,
    output logic [WORD_W-1:0] dataOut,
    output logic              done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned BLK_W = ADDR_W - 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [1:0]         beat_q, beat_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [WORD_W-1:0]  mem [DEPTH];
    logic               in_burst;

    // Word-offset bits of the request address do not take part in block selection.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr[1:0];

    // Storage array; writes are accepted in every state and are not reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // State, counters and latched block address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
        end
    end

    // Next-state logic: accept in IDLE, count latency, count four beats, one done cycle.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        blk_d   = blk_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    blk_d   = addr[ADDR_W-1:2];
                    lat_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_q == CNT_W'(LATENCY - 1)) begin
                    beat_d  = 2'd0;
                    state_d = S_BURST;
                end else begin
                    lat_d = CNT_W'(lat_q + CNT_W'(1));
                end
            end
            S_BURST: begin
                if (beat_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = 2'(beat_q + 2'd1);
                end
            end
            S_DONE: begin
                beat_d  = 2'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state and counters; read is combinational so a
    // same-cycle write shows up only after the edge that commits it.
    always_comb begin
        in_burst = (state_q == S_BURST);
        busy     = (state_q != S_IDLE);
        ready    = in_burst;
        done     = (state_q == S_DONE);
        offset   = in_burst ? beat_q : 2'd0;
        dataOut  = in_burst ? mem[{blk_q, beat_q}] : '0;
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: a LATENCY=4 and a LATENCY=1 instance
// share all inputs and are checked cycle by cycle against a timeline model.
module tb_main_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [11:0] addr;
    logic        wrEn;
    logic [11:0] wrAddr;
    logic [31:0] wrData;

    logic        busy4, ready4, done4, busy1, ready1, done1;
    logic [1:0]  offset4, offset1;
    logic [31:0] data4, data1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [11:0]      a;
        logic [3:0][31:0] d;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    main_mem_responder #(.WORD_W(32), .ADDR_W(12), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst), .req(req), .addr(addr),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .busy(busy4), .ready(ready4), .offset(offset4), .dataOut(data4), .done(done4)
    );

    main_mem_responder #(.WORD_W(32), .ADDR_W(12), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .req(req), .addr(addr),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .busy(busy1), .ready(ready1), .offset(offset1), .dataOut(data1), .done(done1)
    );

    // Expected {busy, ready, offset, dataOut, done} j cycles after acceptance.
    function automatic logic [36:0] model(input int lat, input int j, input logic [3:0][31:0] d);
        if (j < lat)           return {1'b1, 1'b0, 2'd0, 32'd0, 1'b0};
        else if (j < lat + 4)  return {1'b1, 1'b1, 2'(j - lat), d[j - lat], 1'b0};
        else if (j == lat + 4) return {1'b1, 1'b0, 2'd0, 32'd0, 1'b1};
        else                   return '0;
    endfunction

    function automatic logic [3:0][31:0] mk(input logic [31:0] d0, input logic [31:0] d1,
                                            input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string nm, input int lat, input int j, input logic [3:0][31:0] d);
        logic [36:0] act, exp;
        exp = model(lat, j, d);
        if (lat == 4) act = {busy4, ready4, offset4, data4, done4};
        else          act = {busy1, ready1, offset1, data1, done1};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lat=%0d j=%0d got{busy,ready,off,data,done}=%h expected=%h",
                     nm, lat, j, act, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        wrEn = 1'b1; wrAddr = a; wrData = d;
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    // One request; optional write at cycle wr_j, optional reset at cycle abort_j.
    task automatic xfer(input string nm, input logic [11:0] a, input logic [3:0][31:0] d,
                        input int wr_j, input logic [11:0] wa, input logic [31:0] wd,
                        input int abort_j);
        @(negedge clk);
        addr = a; req = 1'b1;
        @(negedge clk);
        for (int j = 0; j <= 10; j++) begin
            req    = (j <= 3);
            addr   = ~a;
            wrEn   = (j == wr_j);
            wrAddr = wa;
            wrData = wd;
            if (j == abort_j) begin
                rst = 1'b1;
                #1;
                chk({nm, "_rst_async"}, 4, 100, d);
                chk({nm, "_rst_async"}, 1, 100, d);
                @(negedge clk);
                rst = 1'b0; req = 1'b0; wrEn = 1'b0;
                for (int m = 0; m < 8; m++) begin
                    #1;
                    chk({nm, "_after_abort"}, 4, 100, d);
                    chk({nm, "_after_abort"}, 1, 100, d);
                    @(negedge clk);
                end
                return;
            end
            #1;
            chk(nm, 4, j, d);
            chk(nm, 1, j, d);
            @(negedge clk);
        end
        req = 1'b0; wrEn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; wrEn = 1'b0; wrAddr = '0; wrData = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", 4, 100, '0);
        chk("reset_state", 1, 100, '0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            wr(12'(12'h010 + i), 32'(32'hA0 + i));
            wr(12'(12'hFFC + i), 32'(32'hF000_00F0 + i));
            wr(12'(12'h000 + i), 32'(32'hB0 + i));
            wr(12'(12'h7A4 + i), 32'(32'hC0 + i));
        end

        tbl[0] = '{a: 12'h012, d: mk(32'hA0, 32'hA1, 32'hA2, 32'hA3)};
        tbl[1] = '{a: 12'h010, d: mk(32'hA0, 32'hA1, 32'hA2, 32'hA3)};
        tbl[2] = '{a: 12'hFFF, d: mk(32'hF000_00F0, 32'hF000_00F1, 32'hF000_00F2, 32'hF000_00F3)};
        tbl[3] = '{a: 12'hFFC, d: mk(32'hF000_00F0, 32'hF000_00F1, 32'hF000_00F2, 32'hF000_00F3)};
        tbl[4] = '{a: 12'h000, d: mk(32'hB0, 32'hB1, 32'hB2, 32'hB3)};
        tbl[5] = '{a: 12'h7A6, d: mk(32'hC0, 32'hC1, 32'hC2, 32'hC3)};

        for (int i = 0; i < 6; i++) begin
            xfer($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, -1, '0, '0, -1);
        end

        // Back-to-back with req held: periods of LATENCY+6 cycles.
        @(negedge clk);
        addr = 12'h7A4; req = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            #1;
            chk("back2back", 4, j % 10, tbl[5].d);
            chk("back2back", 1, j % 7, tbl[5].d);
            @(negedge clk);
        end
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Collision: write 0x55 to word 0x11 during the offset-1 beat of the LATENCY=4 unit.
        xfer("collide", 12'h010, tbl[1].d, 5, 12'h011, 32'h55, -1);
        xfer("after_collide", 12'h011, mk(32'hA0, 32'h55, 32'hA2, 32'hA3), -1, '0, '0, -1);

        // Reset during WAIT, then during beat 2; each followed by a normal transfer.
        xfer("abort_wait", 12'h7A5, tbl[5].d, -1, '0, '0, 2);
        xfer("post_abort_wait", 12'h7A5, tbl[5].d, -1, '0, '0, -1);
        xfer("abort_beat2", 12'hFFE, tbl[2].d, -1, '0, '0, 6);
        xfer("post_abort_beat2", 12'hFFE, tbl[2].d, -1, '0, '0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 Parameter WORD_W, default 32: data word width in bits.
REQ-002 Parameter ADDR_W, default 12: word-address width; memory depth is 2^ADDR_W words.
REQ-003 Parameter LATENCY, default 4: access delay in cycles, legal range 1..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req  input  1  block-read request, sampled only in IDLE.
REQ-008 addr  input  ADDR_W  request word address; bits [1:0] ignored, bits [ADDR_W-1:2] select the 4-word block.
REQ-009 wrEn  input  1  single-word write strobe.
REQ-010 wrAddr  input  ADDR_W  write word address.
REQ-011 wrData  input  WORD_W  write data.
REQ-012 busy  output  1  high in WAIT, BURST and DONE.
REQ-013 ready  output  1  high on each valid burst beat.
REQ-014 offset  output  2  word index of the current beat.
REQ-015 dataOut  output  WORD_W  burst data; zero when ready=0.
REQ-016 done  output  1  one-cycle end-of-transfer pulse.

Function
REQ-017 Registered state machine with states IDLE, WAIT, BURST, DONE; all outputs decoded from state and counters only (Moore).
REQ-018 IDLE: if req=1 at a rising edge, the block SHALL latch addr[ADDR_W-1:2] into blkReg, clear the latency counter, and go to WAIT; otherwise it SHALL stay in IDLE.
REQ-019 WAIT: the block SHALL stay for exactly LATENCY cycles, then go to BURST with beat counter = 0.
REQ-020 BURST: the block SHALL spend exactly 4 cycles, with ready=1, offset = beat counter (0,1,2,3) and dataOut = mem[{blkReg, offset}]; after beat 3 it SHALL go to DONE.
REQ-021 DONE: the block SHALL spend exactly 1 cycle with done=1, then return to IDLE.
REQ-022 Timing: with req sampled at edge k, WAIT SHALL cover cycles k+1..k+LATENCY, beats cycles k+LATENCY+1..k+LATENCY+4, done cycle k+LATENCY+5, and req SHALL be accepted again at edge k+LATENCY+6 at the earliest.
REQ-023 req outside IDLE SHALL be ignored, with no queuing; addr changes after acceptance SHALL have no effect.
REQ-024 Writes: wrEn=1 at an edge SHALL store wrData into mem[wrAddr] in any state.
REQ-025 Write/read collision: when a write targets the word being read in the same cycle, dataOut SHALL show the old value that cycle, and later beats or requests SHALL see the new value.
REQ-026 Outside BURST: ready=0, offset=0, dataOut=0.
REQ-027 Block address arithmetic SHALL be {blkReg, offset} with no carry into blkReg; the highest block (all ones) SHALL read words 2^ADDR_W-4..2^ADDR_W-1 without wrap into block 0.

Reset
REQ-028 On rst=1, state SHALL go to IDLE immediately, without waiting for clk, and the counters and blkReg SHALL be cleared.
REQ-029 During reset: busy=0, ready=0, done=0, offset=0, dataOut=0.
REQ-030 Memory contents SHALL NOT be altered by rst.
REQ-031 Reset mid-burst SHALL abort the transfer with no done pulse; the first req after rst deasserts SHALL start a fresh full transfer.

Verification
REQ-032 Basic read, LATENCY=4: write words 0x10..0x13 with 0xA0..0xA3, then req with addr=0x12 at edge k -> ready high k+5..k+8, offset 0..3, dataOut 0xA0..0xA3, done at k+9, busy low at k+10.
REQ-033 Back-to-back: hold req=1 continuously -> second transfer begins exactly at edge k+10; no request accepted while busy=1.
REQ-034 Collision: during the beat with offset=1, write 0x55 to word 0x11 -> that beat shows 0xA1; a repeated request returns 0x55 at offset 1.
REQ-035 Top block: addr = all ones -> beats read the last four words in order; block 0 is not read.
REQ-036 Reset mid-operation: assert rst during the WAIT state and during beat 2 -> outputs go to 0 asynchronously, no done pulse, memory intact; the next request completes normally.
REQ-037 LATENCY=1 build: req at edge k -> first beat at cycle k+2, done at cycle k+6.
